led_trail_pwm: RTL and testbench

//  Downstream stage of the knight_rider LED pattern generator, in the lclk (125 MHz) domain.

---
 rtl/led_trail_pwm.sv | 146 ++++++++++++++
 tb/tb_led_trail_pwm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_trail_pwm.sv
// led_trail_pwm
//   Per-LED PWM brightness stage with a fading trail, downstream of the
//   knight_rider pattern generator (lclk domain). A lit pattern bit loads
//   full brightness; once it clears, brightness decays by DECAY_STEP on
//   every decay tick (one tick per DECAY_DIV cycles), saturating at zero.
//   Each channel's duty is compared against a free-running PWM counter to
//   produce a registered LED drive, gated by en.
//
//   Optional build macro: LED_TRAIL_GAMMA_EN
//     defined   -> duty = (bright*bright) >> PWM_BITS through an extra register
//                  stage (bright==MAX still maps to MAX); bright->led is 2 cycles.
//     undefined -> duty = bright (linear); bright->led is 1 cycle.
module led_trail_pwm #(
   parameter int N_LEDS     = 8,
   parameter int PWM_BITS   = 8,
   parameter int DECAY_DIV  = 125000,
   parameter int DECAY_STEP = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N_LEDS-1:0] pattern,
   output logic [N_LEDS-1:0] led,
   output logic              pwm_sync
);

   localparam int                  DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

   // Decrement by one step, clamping at zero so a dim channel never wraps to bright.
   function automatic logic [PWM_BITS-1:0] sat_decay(input logic [PWM_BITS-1:0] b);
      if (b < STEP) begin
         return '0;
      end
      return b - STEP;
   endfunction

`ifdef LED_TRAIL_GAMMA_EN
   // Square-law perceptual correction; full brightness stays exactly full.
   function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] b);
      logic [2*PWM_BITS-1:0] prod;
      prod = (2*PWM_BITS)'(b) * (2*PWM_BITS)'(b);
      if (b == MAX) begin
         return MAX;
      end
      return prod[2*PWM_BITS-1:PWM_BITS];
   endfunction
`endif

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                pwm_sync_q, pwm_sync_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic                tick;
   logic [PWM_BITS-1:0] bright_q [N_LEDS];
   logic [PWM_BITS-1:0] bright_d [N_LEDS];
   logic [PWM_BITS-1:0] duty     [N_LEDS];
   logic [N_LEDS-1:0]   led_q, led_d;

   // Free-running PWM counter, sync pulse lookahead and decay divider.
   always_comb begin
      pwm_cnt_d  = pwm_cnt_q + 1'b1;
      // Registered one cycle early so the pulse lines up with pwm_cnt==0; the
      // cycle right after reset never sees a pulse because pwm_cnt was not MAX.
      pwm_sync_d = (pwm_cnt_q == MAX);
      tick       = (div_cnt_q == DIV_LAST);
      div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
   end

   // Per-channel brightness: reload wins over a simultaneous decay tick.
   always_comb begin
      for (int i = 0; i < N_LEDS; i++) begin
         bright_d[i] = bright_q[i];
         if (pattern[i]) begin
            bright_d[i] = MAX;
         end else if (tick) begin
            bright_d[i] = sat_decay(bright_q[i]);
         end
      end
   end

`ifdef LED_TRAIL_GAMMA_EN
   logic [PWM_BITS-1:0] duty_q [N_LEDS];

   // Gamma-corrected duty register; adds one cycle between bright and led.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_LEDS; i++) begin
            duty_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_LEDS; i++) begin
            duty_q[i] <= gamma_map(bright_q[i]);
         end
      end
   end

   // Duty taken from the gamma register.
   always_comb begin
      for (int i = 0; i < N_LEDS; i++) begin
         duty[i] = duty_q[i];
      end
   end
`else
   // Linear mapping: duty is brightness itself.
   always_comb begin
      for (int i = 0; i < N_LEDS; i++) begin
         duty[i] = bright_q[i];
      end
   end
`endif

   // PWM compare; MAX is forced fully on since duty > pwm_cnt alone would miss one cycle.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < N_LEDS; i++) begin
         led_d[i] = en & ((duty[i] == MAX) | (duty[i] > pwm_cnt_q));
      end
   end

   // State registers; reset clears counters, brightness and outputs together.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q  <= '0;
         pwm_sync_q <= 1'b0;
         div_cnt_q  <= '0;
         led_q      <= '0;
         for (int i = 0; i < N_LEDS; i++) begin
            bright_q[i] <= '0;
         end
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         pwm_sync_q <= pwm_sync_d;
         div_cnt_q  <= div_cnt_d;
         led_q      <= led_d;
         for (int i = 0; i < N_LEDS; i++) begin
            bright_q[i] <= bright_d[i];
         end
      end
   end

   assign led      = led_q;
   assign pwm_sync = pwm_sync_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Testbench for led_trail_pwm: directed scenarios plus randomized traffic,
// compared cycle by cycle against an integer behavioural model.
module tb_led_trail_pwm;
   localparam int N    = 8;
   localparam int DIV  = 4;
   localparam int STEP = 64;
   localparam int MAXV = 255;
   localparam int PER  = 256;
`ifdef LED_TRAIL_GAMMA_EN
   localparam bit GAMMA = 1'b1;
`else
   localparam bit GAMMA = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [N-1:0] pattern;
   logic [N-1:0] led;
   logic         pwm_sync;
   logic [0:0]   pat2;
   logic [0:0]   led2;
   logic         sync2;

   int checks = 0;
   int errors = 0;
   bit model_on = 1'b0;

   // model state
   int           t;
   int           mb [N];
   int           mg [N];
   logic [N-1:0] mled;
   logic         msync;

   always #4 clk = ~clk;

   led_trail_pwm #(.N_LEDS(N), .PWM_BITS(8), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) dut (
      .clk(clk), .rst(rst), .en(en), .pattern(pattern), .led(led), .pwm_sync(pwm_sync));

   led_trail_pwm #(.N_LEDS(1), .PWM_BITS(8), .DECAY_DIV(600), .DECAY_STEP(127)) dut2 (
      .clk(clk), .rst(rst), .en(1'b1), .pattern(pat2), .led(led2), .pwm_sync(sync2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: t counts cycles since reset; pwm count is t mod 256,
   // decay ticks land where t mod DIV == DIV-1.
   always @(posedge clk) begin
      if (rst) begin
         t = 0;
         for (int i = 0; i < N; i++) begin
            mb[i] = 0;
            mg[i] = 0;
         end
         mled  = '0;
         msync = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            int d;
            d = GAMMA ? mg[i] : mb[i];
            mled[i] = en && (d == MAXV || d > (t % PER));
         end
         msync = ((t % PER) == PER - 1);
         for (int i = 0; i < N; i++) begin
            mg[i] = (mb[i] == MAXV) ? MAXV : (mb[i] * mb[i]) / 256;
            if (pattern[i])
               mb[i] = MAXV;
            else if ((t % DIV) == DIV - 1)
               mb[i] = (mb[i] - STEP < 0) ? 0 : mb[i] - STEP;
         end
         t++;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("model_led", led, mled);
         check("model_sync", pwm_sync, msync);
      end
   end

   initial begin
      int vals[$];
      int when[$];
      int prev;
      int k;
      int cnt;
      rst = 1'b1; en = 1'b1; pattern = '0; pat2 = '0;
      step(1);
      model_on = 1'b1;
      step(2);
      check("rst_led", led, 8'h00);
      check("rst_sync", pwm_sync, 1'b0);
      rst = 1'b0;

      // steady single lit LED over two PWM periods
      pattern = 8'h01;
      step(4);
      for (int c = 0; c < 2 * PER; c++) begin
         step(1);
         check("t2_led", led, 8'h01);
      end

      // one-cycle pulse then decay staircase
      pattern = '0;
      step(24);
      check("t3_idle", dut.bright_q[0], 0);
      pattern = 8'h01;
      step(1);
      pattern = '0;
      prev = -1;
      for (int c = 0; c < 30; c++) begin
         if (int'(dut.bright_q[0]) != prev) begin
            prev = int'(dut.bright_q[0]);
            vals.push_back(prev);
            when.push_back(c);
         end
         step(1);
      end
      check("t3_steps", vals.size(), 5);
      for (int j = 0; j < vals.size() && j < 5; j++)
         check("t3_val", vals[j], (MAXV - STEP * j < 0) ? 0 : MAXV - STEP * j);
      for (int j = 1; j + 1 < when.size() && j < 4; j++)
         check("t3_gap", when[j+1] - when[j], DIV);
      check("t3_final", dut.bright_q[0], 0);

      // enable gating
      pattern = 8'hFF;
      step(4);
      check("t4_on", led, 8'hFF);
      en = 1'b0;
      step(1);
      check("t4_off", led, 8'h00);
      step(3);
      check("t4_off_hold", led, 8'h00);
      en = 1'b1;
      step(1);
      check("t4_back", led, 8'hFF);

      // reload coinciding with a tick at bright=63
      pattern = '0;
      step(24);
      pattern = 8'h08;
      step(1);
      pattern = '0;
      k = 0;
      while (!(mb[3] == 63 && (t % DIV) == DIV - 1) && k < 40) begin
         step(1);
         k++;
      end
      check("t5_align", (k < 40), 1'b1);
      pattern = 8'h08;
      step(1);
      check("t5_bright", dut.bright_q[3], 255);
      pattern = '0;
      step(2);
      check("t5_led", led[3], 1'b1);

      // reset mid-fade, then time the first sync pulse
      pattern = 8'h81;
      step(6);
      pattern = '0;
      step(2);
      rst = 1'b1;
      step(1);
      check("t1_led", led, 8'h00);
      check("t1_sync", pwm_sync, 1'b0);
      check("t1_bright", dut.bright_q[7], 0);
      step(2);
      check("t1_led_held", led, 8'h00);
      rst = 1'b0;
      k = 0;
      do begin
         step(1);
         k++;
      end while (!pwm_sync && k < 600);
      check("t1_first_sync", k, PER);

      // duty 128 high-cycle count on the second instance
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      pat2 = 1'b1;
      step(10);
      pat2 = 1'b0;
      k = 0;
      while (t < 800 && k < 2000) begin
         step(1);
         k++;
      end
      cnt = 0;
      for (int c = 0; c < PER; c++) begin
         step(1);
         cnt += int'(led2[0]);
      end
      check("t6_high", cnt, GAMMA ? 64 : 128);

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         pattern = N'($urandom & $urandom & $urandom);
         en      = ($urandom_range(0, 15) != 0);
         rst     = ($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);

      model_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
